// File: rtl/ccu_snoop_arbiter.sv
// ccu_snoop_arbiter
// Shares the single CCU snoop master port (AC/CR/CD) between the read-snoop
// controller (req0) and the write-snoop controller (req1). The AC request is
// arbitrated round-robin, and the grant is held for the whole snoop transaction:
// AC, then CR, then an optional CD burst. CR and CD go back only to the owner.
//
// Handshake rule for every channel: a beat transfers on a rising clk_i edge
// where valid and ready are both 1. Valid does not wait for ready. This block
// only routes valid and ready between the owner and the snoop port. It never
// holds a beat in a buffer.
//
// Optional feature: define SNOOP_ARB_TIMEOUT_EN to add a watchdog on RESP/DATA.
// A timeout sets err_o and forces the FSM back to IDLE.
module ccu_snoop_arbiter #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 64,
  parameter int CdBeats       = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // requester 0 (read-snoop ctrl)
  input  logic                 req0_ac_valid_i,
  output logic                 req0_ac_ready_o,
  input  logic [AddrWidth-1:0] req0_ac_addr_i,
  input  logic [3:0]           req0_ac_snoop_i,
  output logic                 req0_cr_valid_o,
  input  logic                 req0_cr_ready_i,
  output logic [4:0]           req0_cr_resp_o,
  output logic                 req0_cd_valid_o,
  input  logic                 req0_cd_ready_i,
  output logic [DataWidth-1:0] req0_cd_data_o,
  output logic                 req0_cd_last_o,
  // requester 1 (write-snoop ctrl)
  input  logic                 req1_ac_valid_i,
  output logic                 req1_ac_ready_o,
  input  logic [AddrWidth-1:0] req1_ac_addr_i,
  input  logic [3:0]           req1_ac_snoop_i,
  output logic                 req1_cr_valid_o,
  input  logic                 req1_cr_ready_i,
  output logic [4:0]           req1_cr_resp_o,
  output logic                 req1_cd_valid_o,
  input  logic                 req1_cd_ready_i,
  output logic [DataWidth-1:0] req1_cd_data_o,
  output logic                 req1_cd_last_o,
  // snoop master port
  output logic                 ac_valid_o,
  input  logic                 ac_ready_i,
  output logic [AddrWidth-1:0] ac_addr_o,
  output logic [3:0]           ac_snoop_o,
  input  logic                 cr_valid_i,
  output logic                 cr_ready_o,
  input  logic [4:0]           cr_resp_i,
  input  logic                 cd_valid_i,
  output logic                 cd_ready_o,
  input  logic [DataWidth-1:0] cd_data_i,
  input  logic                 cd_last_i,
  // status
  output logic                 grant_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [1:0]           state_o
);

  localparam int BeatW = $clog2(CdBeats) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AC   = 2'd1,
    S_RESP = 2'd2,
    S_DATA = 2'd3
  } state_t;

  // Stop elaboration if the parameters cannot describe a real snoop port.
  if (CdBeats < 1 || TimeoutCycles < 1) begin : g_bad_param
    $error("ccu_snoop_arbiter: CdBeats and TimeoutCycles must be >= 1");
  end

  state_t           r_state;
  logic             r_grant;
  logic             r_rr_ptr;
  logic             r_err;
  logic [BeatW-1:0] r_beat_cnt;

  logic w_g_ac_valid;
  logic w_g_cr_ready;
  logic w_g_cd_ready;
  logic w_ac_hs;
  logic w_cr_hs;
  logic w_cd_hs;
  logic w_last_beat;
  logic w_timeout;

  assign w_g_ac_valid = r_grant ? req1_ac_valid_i : req0_ac_valid_i;
  assign w_g_cr_ready = r_grant ? req1_cr_ready_i : req0_cr_ready_i;
  assign w_g_cd_ready = r_grant ? req1_cd_ready_i : req0_cd_ready_i;
  assign w_ac_hs      = (r_state == S_AC)   && w_g_ac_valid && ac_ready_i;
  assign w_cr_hs      = (r_state == S_RESP) && cr_valid_i   && w_g_cr_ready;
  assign w_cd_hs      = (r_state == S_DATA) && cd_valid_i   && w_g_cd_ready;
  assign w_last_beat  = (r_beat_cnt == BeatW'(CdBeats - 1));

`ifdef SNOOP_ARB_TIMEOUT_EN
  logic [15:0] r_wd_cnt;

  // Watchdog: count the cycles spent in RESP/DATA. Restart on entry to either state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd_cnt <= 16'd0;
    end else if (w_ac_hs || w_cr_hs || w_timeout ||
                 !((r_state == S_RESP) || (r_state == S_DATA))) begin
      r_wd_cnt <= 16'd0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  assign w_timeout = ((r_state == S_RESP) || (r_state == S_DATA)) &&
                     (r_wd_cnt == 16'(TimeoutCycles - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Transaction FSM: grant selection, grant lock, beat counting and sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_grant    <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_timeout) begin
      r_state    <= S_IDLE;
      r_err      <= 1'b1;
      r_rr_ptr   <= ~r_grant;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0_ac_valid_i || req1_ac_valid_i) begin
            // When both request, the round-robin pointer decides. Otherwise the single requester wins.
            r_grant <= (req0_ac_valid_i && req1_ac_valid_i) ? r_rr_ptr : req1_ac_valid_i;
            r_state <= S_AC;
          end
        end
        S_AC: begin
          if (w_ac_hs) r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_cr_hs) begin
            if (cr_resp_i[0]) begin
              r_state    <= S_DATA;
              r_beat_cnt <= '0;
            end else begin
              r_state  <= S_IDLE;
              r_rr_ptr <= ~r_grant;
            end
          end
        end
        S_DATA: begin
          if (w_cd_hs) begin
            // The beat counter ends the burst. cd_last_i is only checked against it.
            if (cd_last_i != w_last_beat) r_err <= 1'b1;
            if (w_last_beat) begin
              r_state    <= S_IDLE;
              r_rr_ptr   <= ~r_grant;
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + BeatW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Routing: only the current phase of the owner is connected. Everything else is 0.
  always_comb begin
    ac_valid_o      = 1'b0;
    ac_addr_o       = '0;
    ac_snoop_o      = 4'd0;
    cr_ready_o      = 1'b0;
    cd_ready_o      = 1'b0;
    req0_ac_ready_o = 1'b0;
    req1_ac_ready_o = 1'b0;
    req0_cr_valid_o = 1'b0;
    req1_cr_valid_o = 1'b0;
    req0_cr_resp_o  = 5'd0;
    req1_cr_resp_o  = 5'd0;
    req0_cd_valid_o = 1'b0;
    req1_cd_valid_o = 1'b0;
    req0_cd_data_o  = '0;
    req1_cd_data_o  = '0;
    req0_cd_last_o  = 1'b0;
    req1_cd_last_o  = 1'b0;
    case (r_state)
      S_AC: begin
        ac_valid_o = w_g_ac_valid;
        ac_addr_o  = r_grant ? req1_ac_addr_i  : req0_ac_addr_i;
        ac_snoop_o = r_grant ? req1_ac_snoop_i : req0_ac_snoop_i;
        if (r_grant) req1_ac_ready_o = ac_ready_i;
        else         req0_ac_ready_o = ac_ready_i;
      end
      S_RESP: begin
        cr_ready_o = w_g_cr_ready;
        if (r_grant) begin
          req1_cr_valid_o = cr_valid_i;
          req1_cr_resp_o  = cr_resp_i;
        end else begin
          req0_cr_valid_o = cr_valid_i;
          req0_cr_resp_o  = cr_resp_i;
        end
      end
      S_DATA: begin
        cd_ready_o = w_g_cd_ready;
        if (r_grant) begin
          req1_cd_valid_o = cd_valid_i;
          req1_cd_data_o  = cd_data_i;
          req1_cd_last_o  = cd_last_i;
        end else begin
          req0_cd_valid_o = cd_valid_i;
          req0_cd_data_o  = cd_data_i;
          req0_cd_last_o  = cd_last_i;
        end
      end
      default: ;
    endcase
  end

  assign grant_o = r_grant;
  assign busy_o  = (r_state != S_IDLE);
  assign err_o   = r_err;
  assign state_o = r_state;

endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// Directed bench for ccu_snoop_arbiter. CdBeats is 4. TimeoutCycles is 16, so
// the watchdog scenario is short when SNOOP_ARB_TIMEOUT_EN is defined.
module tb_ccu_snoop_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_ac_valid_i, req0_ac_ready_o;
  logic [31:0] req0_ac_addr_i;
  logic [3:0]  req0_ac_snoop_i;
  logic        req0_cr_valid_o, req0_cr_ready_i;
  logic [4:0]  req0_cr_resp_o;
  logic        req0_cd_valid_o, req0_cd_ready_i;
  logic [63:0] req0_cd_data_o;
  logic        req0_cd_last_o;
  logic        req1_ac_valid_i, req1_ac_ready_o;
  logic [31:0] req1_ac_addr_i;
  logic [3:0]  req1_ac_snoop_i;
  logic        req1_cr_valid_o, req1_cr_ready_i;
  logic [4:0]  req1_cr_resp_o;
  logic        req1_cd_valid_o, req1_cd_ready_i;
  logic [63:0] req1_cd_data_o;
  logic        req1_cd_last_o;
  logic        ac_valid_o, ac_ready_i;
  logic [31:0] ac_addr_o;
  logic [3:0]  ac_snoop_o;
  logic        cr_valid_i, cr_ready_o;
  logic [4:0]  cr_resp_i;
  logic        cd_valid_i, cd_ready_o;
  logic [63:0] cd_data_i;
  logic        cd_last_i;
  logic        grant_o, busy_o, err_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  ccu_snoop_arbiter #(
    .AddrWidth(32), .DataWidth(64), .CdBeats(4), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_ac_valid_i(req0_ac_valid_i), .req0_ac_ready_o(req0_ac_ready_o),
    .req0_ac_addr_i(req0_ac_addr_i), .req0_ac_snoop_i(req0_ac_snoop_i),
    .req0_cr_valid_o(req0_cr_valid_o), .req0_cr_ready_i(req0_cr_ready_i),
    .req0_cr_resp_o(req0_cr_resp_o),
    .req0_cd_valid_o(req0_cd_valid_o), .req0_cd_ready_i(req0_cd_ready_i),
    .req0_cd_data_o(req0_cd_data_o), .req0_cd_last_o(req0_cd_last_o),
    .req1_ac_valid_i(req1_ac_valid_i), .req1_ac_ready_o(req1_ac_ready_o),
    .req1_ac_addr_i(req1_ac_addr_i), .req1_ac_snoop_i(req1_ac_snoop_i),
    .req1_cr_valid_o(req1_cr_valid_o), .req1_cr_ready_i(req1_cr_ready_i),
    .req1_cr_resp_o(req1_cr_resp_o),
    .req1_cd_valid_o(req1_cd_valid_o), .req1_cd_ready_i(req1_cd_ready_i),
    .req1_cd_data_o(req1_cd_data_o), .req1_cd_last_o(req1_cd_last_o),
    .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i),
    .ac_addr_o(ac_addr_o), .ac_snoop_o(ac_snoop_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
    .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o),
    .cd_data_i(cd_data_i), .cd_last_i(cd_last_i),
    .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o), .state_o(state_o)
  );

  // clock / global time limit
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL sim_timeout: run did not finish, got timeout exp summary");
    $fatal(1, "simulation time limit");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    req0_ac_valid_i = 0; req0_ac_addr_i = '0; req0_ac_snoop_i = '0;
    req0_cr_ready_i = 0; req0_cd_ready_i = 0;
    req1_ac_valid_i = 0; req1_ac_addr_i = '0; req1_ac_snoop_i = '0;
    req1_cr_ready_i = 0; req1_cd_ready_i = 0;
    ac_ready_i = 1; cr_valid_i = 0; cr_resp_i = '0;
    cd_valid_i = 0; cd_data_i = '0; cd_last_i = 0;
  endtask

  // Called at the first RESP cycle. Ends the transaction with a dataless CR.
  task automatic cr_nodata(input logic g);
    if (g) begin req1_ac_valid_i = 0; req1_cr_ready_i = 1; end
    else   begin req0_ac_valid_i = 0; req0_cr_ready_i = 1; end
    cr_valid_i = 1; cr_resp_i = 5'b00000;
    cyc();
    cr_valid_i = 0; req0_cr_ready_i = 0; req1_cr_ready_i = 0;
  endtask

  task automatic test_reset();
    settle();
    n_checks++;
    if ({busy_o, grant_o, err_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_status: got busy/grant/err=%b exp 000", {busy_o, grant_o, err_o});
    end
    n_checks++;
    if ({ac_valid_o, cr_ready_o, cd_ready_o, req0_ac_ready_o, req1_ac_ready_o,
         req0_cr_valid_o, req1_cr_valid_o, req0_cd_valid_o, req1_cd_valid_o} !== 9'd0) begin
      n_fail++; $display("FAIL reset_handshakes: got nonzero valid/ready exp all 0");
    end
    n_checks++;
    if ({ac_addr_o, req0_cd_data_o, req1_cd_data_o} !== 160'd0) begin
      n_fail++; $display("FAIL reset_data: got nonzero data outputs exp 0");
    end
    cyc();
    rst_i = 0;
    settle();
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_busy: got %0b exp 0", busy_o);
    end
  endtask

  task automatic test_req0_only();
    cyc();
    req0_ac_valid_i = 1; req0_ac_addr_i = 32'h1000_0040; req0_ac_snoop_i = 4'h1;
    settle();
    n_checks++;
    if (ac_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL req0_latency: got ac_valid=%0b busy=%0b exp 0 0", ac_valid_o, busy_o);
    end
    cyc();
    settle();
    n_checks++;
    if ({ac_valid_o, ac_addr_o, ac_snoop_o, grant_o} !== {1'b1, 32'h1000_0040, 4'h1, 1'b0}) begin
      n_fail++; $display("FAIL req0_ac_fwd: got v=%0b a=%h s=%h g=%0b exp 1 10000040 1 0",
                         ac_valid_o, ac_addr_o, ac_snoop_o, grant_o);
    end
    n_checks++;
    if ({req0_ac_ready_o, req1_ac_ready_o} !== 2'b10) begin
      n_fail++; $display("FAIL req0_ac_ready: got %b exp 10", {req0_ac_ready_o, req1_ac_ready_o});
    end
    cyc();
    req0_ac_valid_i = 0; cr_valid_i = 1; cr_resp_i = 5'b00000; req0_cr_ready_i = 1;
    settle();
    n_checks++;
    if ({req0_cr_valid_o, req1_cr_valid_o, cr_ready_o, ac_valid_o} !== 4'b1010) begin
      n_fail++; $display("FAIL req0_cr_route: got %b exp 1010",
                         {req0_cr_valid_o, req1_cr_valid_o, cr_ready_o, ac_valid_o});
    end
    cyc();
    cr_valid_i = 0; req0_cr_ready_i = 0;
    settle();
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL req0_done_idle: got busy=%0b exp 0", busy_o);
    end
  endtask

  // Both requesters present. first_g is the owner expected first.
  task automatic test_both(input logic first_g, input string tag);
    cyc();
    req0_ac_valid_i = 1; req0_ac_addr_i = 32'hA000_0000; req0_ac_snoop_i = 4'h2;
    req1_ac_valid_i = 1; req1_ac_addr_i = 32'hB000_0000; req1_ac_snoop_i = 4'h3;
    cyc();
    settle();
    n_checks++;
    if (grant_o !== first_g || ac_addr_o !== (first_g ? 32'hB000_0000 : 32'hA000_0000)) begin
      n_fail++; $display("FAIL %s_first_grant: got g=%0b a=%h exp g=%0b", tag, grant_o, ac_addr_o, first_g);
    end
    n_checks++;
    if ({req1_ac_ready_o, req0_ac_ready_o} !== (first_g ? 2'b10 : 2'b01)) begin
      n_fail++; $display("FAIL %s_first_ready: got %b exp only owner ready", tag, {req1_ac_ready_o, req0_ac_ready_o});
    end
    cyc();
    cr_nodata(first_g);
    settle();
    n_checks++;
    if (busy_o !== 1'b0 || ac_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_bubble: got busy=%0b ac_valid=%0b exp 0 0", tag, busy_o, ac_valid_o);
    end
    cyc();
    settle();
    n_checks++;
    if (grant_o !== ~first_g || ac_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL %s_second_grant: got g=%0b v=%0b exp g=%0b v=1", tag, grant_o, ac_valid_o, ~first_g);
    end
    cyc();
    cr_nodata(~first_g);
  endtask

  // Full data transaction for requester g. The cd_last flag is asserted on beat last_at.
  task automatic test_data(input logic g, input int last_at, input logic exp_err, input string tag);
    int seen;
    seen = 0;
    cyc();
    if (g) begin req1_ac_valid_i = 1; req1_ac_addr_i = 32'hC000_0080; req1_ac_snoop_i = 4'h7; end
    else   begin req0_ac_valid_i = 1; req0_ac_addr_i = 32'hD000_00C0; req0_ac_snoop_i = 4'h9; end
    cyc();
    cyc();
    req0_ac_valid_i = 0; req1_ac_valid_i = 0;
    cr_valid_i = 1; cr_resp_i = 5'b00001;
    if (g) req1_cr_ready_i = 1; else req0_cr_ready_i = 1;
    cd_valid_i = 1; cd_data_i = 64'hDEAD_BEEF_0000_0000;
    settle();
    n_checks++;
    if ((g ? req1_cr_resp_o : req0_cr_resp_o) !== 5'b00001) begin
      n_fail++; $display("FAIL %s_cr_resp: got %b exp 00001", tag, g ? req1_cr_resp_o : req0_cr_resp_o);
    end
    n_checks++;
    if ({cd_ready_o, req0_cd_valid_o, req1_cd_valid_o} !== 3'b000) begin
      n_fail++; $display("FAIL %s_early_cd: got %b exp 000", tag, {cd_ready_o, req0_cd_valid_o, req1_cd_valid_o});
    end
    cyc();
    cr_valid_i = 0; req0_cr_ready_i = 0; req1_cr_ready_i = 0;
    for (int b = 0; b < 4; b++) begin
      cd_valid_i = 1; cd_data_i = 64'hA5A5_0000_0000_0000 | 64'(b); cd_last_i = (b == last_at);
      if (g) req1_cd_ready_i = 1; else req0_cd_ready_i = 1;
      settle();
      if ((g ? req1_cd_valid_o : req0_cd_valid_o) === 1'b1 &&
          (g ? req1_cd_data_o : req0_cd_data_o) === (64'hA5A5_0000_0000_0000 | 64'(b)) &&
          (g ? req1_cd_last_o : req0_cd_last_o) === (b == last_at) &&
          (g ? req0_cd_valid_o : req1_cd_valid_o) === 1'b0 && cd_ready_o === 1'b1 && busy_o === 1'b1)
        seen++;
      cyc();
    end
    cd_valid_i = 0; cd_last_i = 0; req0_cd_ready_i = 0; req1_cd_ready_i = 0;
    settle();
    n_checks++;
    if (seen !== 4) begin
      n_fail++; $display("FAIL %s_beats: got %0d forwarded beats exp 4", tag, seen);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_drop: got %0b exp 0", tag, busy_o);
    end
    n_checks++;
    if (err_o !== exp_err) begin
      n_fail++; $display("FAIL %s_err: got %0b exp %0b", tag, err_o, exp_err);
    end
    repeat (3) cyc();
    settle();
    n_checks++;
    if (err_o !== exp_err) begin
      n_fail++; $display("FAIL %s_err_sticky: got %0b exp %0b", tag, err_o, exp_err);
    end
  endtask

  task automatic test_reset_mid_data();
    cyc();
    req1_ac_valid_i = 1; req1_ac_addr_i = 32'hE000_0000; req1_ac_snoop_i = 4'h7;
    cyc();
    cyc();
    req1_ac_valid_i = 0; cr_valid_i = 1; cr_resp_i = 5'b00001; req1_cr_ready_i = 1;
    cyc();
    cr_valid_i = 0; req1_cr_ready_i = 0;
    cd_valid_i = 1; cd_data_i = 64'h1111; req1_cd_ready_i = 1;
    repeat (2) cyc();
    rst_i = 1;
    settle();
    n_checks++;
    if ({req1_cd_valid_o, req0_cd_valid_o, cd_ready_o, busy_o, err_o, grant_o} !== 6'd0) begin
      n_fail++; $display("FAIL rst_mid_data: got %b exp 000000",
                         {req1_cd_valid_o, req0_cd_valid_o, cd_ready_o, busy_o, err_o, grant_o});
    end
    cyc();
    rst_i = 0; cd_valid_i = 0; req1_cd_ready_i = 0;
    req0_ac_valid_i = 1; req0_ac_addr_i = 32'h0000_0100; req1_ac_valid_i = 1;
    cyc();
    settle();
    n_checks++;
    if (grant_o !== 1'b0 || ac_valid_o !== 1'b1 || ac_addr_o !== 32'h0000_0100) begin
      n_fail++; $display("FAIL rst_next_grant: got g=%0b v=%0b a=%h exp 0 1 00000100", grant_o, ac_valid_o, ac_addr_o);
    end
    cyc();
    cr_nodata(1'b0);
    req1_ac_valid_i = 0;
  endtask

`ifdef SNOOP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    cyc();
    rst_i = 1;
    cyc();
    rst_i = 0; clear_inputs();
    req0_ac_valid_i = 1;
    cyc();
    cyc();
    req0_ac_valid_i = 0; req0_cr_ready_i = 1;
    repeat (15) cyc();
    settle();
    n_checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL wd_before: got err=%0b busy=%0b exp 0 1", err_o, busy_o);
    end
    cyc();
    settle();
    n_checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL wd_expire: got err=%0b busy=%0b exp 1 0", err_o, busy_o);
    end
  endtask
`endif

  initial begin
    rst_i = 1;
    clear_inputs();
    repeat (3) @(posedge clk_i);
    test_reset();
    test_req0_only();
    test_both(1'b1, "rr_after_req0");
    cyc();
    rst_i = 1;
    cyc();
    rst_i = 0;
    test_both(1'b0, "both_after_reset");
    test_data(1'b1, 3, 1'b0, "req1_data");
    test_data(1'b0, 1, 1'b1, "last_mismatch");
    test_reset_mid_data();
`ifdef SNOOP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
